// File: rtl/alu_seq_if.sv
// Instruction, ALU-side and writeback signal bundle for alu_seq.
// master drives instructions and ALU results; slave is the sequencer.
interface alu_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic       in_imm_en;
  logic [7:0] in_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [6:0] alu_op;
  logic [7:0] alu_fi;
  logic [7:0] alu_d;
  logic [7:0] alu_fo;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic [7:0] flags;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, alu_d, alu_fo,
    input  in_ready, alu_a, alu_b, alu_op, alu_fi, wb_valid, wb_rd, wb_data, flags
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, alu_d, alu_fo,
    output in_ready, alu_a, alu_b, alu_op, alu_fi, wb_valid, wb_rd, wb_data, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencer feeding an external multi-cycle ALU from a 4x8 register file and flags register.
// Optional immediate operand b is enabled by defining ALU_SEQ_IMM_EN.
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready high
// ISSUE | operands presented to the ALU (captured on the accept edge)
// WAIT  | remaining ALU latency, down-counter running
// WB    | result written, wb_valid high, may accept the next instruction
module alu_seq #(
  parameter int ALU_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

  localparam int WAIT_INIT = (ALU_LATENCY > 1) ? ALU_LATENCY - 2 : 0;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];
  logic [7:0] flags_q, flags_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [6:0] alu_op_q, alu_op_d;
  logic [7:0] alu_fi_q, alu_fi_d;
  logic [1:0] rd_q, rd_d;
  logic [1:0] wb_rd_q, wb_rd_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       in_ready;
  logic       wb_valid;
  logic       accept;

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rf_q      <= '{default: '0};
      flags_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_fi_q  <= '0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_q      <= rf_d;
      flags_q   <= flags_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_fi_q  <= alu_fi_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        if (ALU_LATENCY == 1) begin
          state_d = WB;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(WAIT_INIT);
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = WB;
        else               cnt_d   = cnt_q - 2'd1;
      end
      WB:      state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback lands on the edge entering WB, before any accept in WB, so a
  // dependent instruction reads the fresh value straight from the register file.
  always_comb begin
    rf_d      = rf_q;
    flags_d   = flags_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_fi_d  = alu_fi_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (accept) begin
      alu_a_d  = rf_q[bus.in_rs1];
`ifdef ALU_SEQ_IMM_EN
      alu_b_d  = bus.in_imm_en ? bus.in_imm : rf_q[bus.in_rs2];
`else
      alu_b_d  = rf_q[bus.in_rs2];
`endif
      alu_op_d = bus.in_op;
      alu_fi_d = flags_q;
      rd_d     = bus.in_rd;
    end
    if (state_d == WB && state_q != WB) begin
      rf_d[rd_q] = bus.alu_d;
      flags_d    = bus.alu_fo;
      wb_rd_d    = rd_q;
      wb_data_d  = bus.alu_d;
    end
  end

  always_comb begin
    in_ready = !rst && (state_q == IDLE || state_q == WB);
    wb_valid = (state_q == WB);
  end

`ifndef ALU_SEQ_IMM_EN
  logic unused_imm;
  assign unused_imm = ^{bus.in_imm_en, bus.in_imm};
`endif

  assign bus.in_ready = in_ready;
  assign bus.wb_valid = wb_valid;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_fi   = alu_fi_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.flags    = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a latency-1 instance under random instructions against a
// register-file model, plus a latency-3 instance for timing and reset abandonment.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  alu_seq_if ifc ();
  alu_seq_if ifc3 ();

  alu_seq #(.ALU_LATENCY(1)) u_dut  (.clk(clk), .rst(rst),  .bus(ifc.slave));
  alu_seq #(.ALU_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(ifc3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_rf [4];
  logic [7:0] ref_flags;
  logic [1:0] ref_wb_rd;
  logic [7:0] ref_wb_data;

  function automatic void chk(input string tag, input logic ok,
                              input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Called #1 after an edge while the latency-1 DUT is in IDLE or WB; returns in its WB cycle.
  task automatic do_instr(input logic [6:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic ie, input logic [7:0] imm,
                          input logic [7:0] d, input logic [7:0] fo);
    logic [7:0] ea, eb;
    ea = ref_rf[rs1];
`ifdef ALU_SEQ_IMM_EN
    eb = ie ? imm : ref_rf[rs2];
`else
    eb = ref_rf[rs2];
`endif
    chk("ready_at_accept", ifc.in_ready === 1'b1, ifc.in_ready, 1'b1);
    ifc.in_valid  = 1'b1;
    ifc.in_op     = op;
    ifc.in_rd     = rd;
    ifc.in_rs1    = rs1;
    ifc.in_rs2    = rs2;
    ifc.in_imm_en = ie;
    ifc.in_imm    = imm;
    @(posedge clk); #1;
    // ISSUE: valid stays high with junk fields, which must be ignored
    ifc.in_op  = 7'($urandom);
    ifc.in_rd  = 2'($urandom);
    ifc.in_rs1 = 2'($urandom);
    ifc.in_rs2 = 2'($urandom);
    ifc.in_imm = 8'($urandom);
    ifc.alu_d  = d;
    ifc.alu_fo = fo;
    chk("issue_ready", ifc.in_ready === 1'b0, ifc.in_ready, 1'b0);
    chk("issue_wb_valid", ifc.wb_valid === 1'b0, ifc.wb_valid, 1'b0);
    chk("issue_alu_a", ifc.alu_a === ea, ifc.alu_a, ea);
    chk("issue_alu_b", ifc.alu_b === eb, ifc.alu_b, eb);
    chk("issue_alu_op", ifc.alu_op === op, ifc.alu_op, op);
    chk("issue_alu_fi", ifc.alu_fi === ref_flags, ifc.alu_fi, ref_flags);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.alu_d    = 8'($urandom);
    ifc.alu_fo   = 8'($urandom);
    chk("wb_valid", ifc.wb_valid === 1'b1, ifc.wb_valid, 1'b1);
    chk("wb_rd", ifc.wb_rd === rd, ifc.wb_rd, rd);
    chk("wb_data", ifc.wb_data === d, ifc.wb_data, d);
    chk("wb_flags", ifc.flags === fo, ifc.flags, fo);
    chk("wb_alu_a_held", ifc.alu_a === ea, ifc.alu_a, ea);
    chk("wb_alu_op_held", ifc.alu_op === op, ifc.alu_op, op);
    chk("wb_ready", ifc.in_ready === 1'b1, ifc.in_ready, 1'b1);
    ref_rf[rd]  = d;
    ref_flags   = fo;
    ref_wb_rd   = rd;
    ref_wb_data = d;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_wb_valid", ifc.wb_valid === 1'b0, ifc.wb_valid, 1'b0);
    chk("idle_ready", ifc.in_ready === 1'b1, ifc.in_ready, 1'b1);
    chk("idle_wb_rd", ifc.wb_rd === ref_wb_rd, ifc.wb_rd, ref_wb_rd);
    chk("idle_wb_data", ifc.wb_data === ref_wb_data, ifc.wb_data, ref_wb_data);
    chk("idle_flags", ifc.flags === ref_flags, ifc.flags, ref_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    rst3 = 1'b1;
    ifc.in_valid = 1'b0;  ifc.in_op = '0;  ifc.in_rd = '0;  ifc.in_rs1 = '0;
    ifc.in_rs2 = '0;  ifc.in_imm_en = 1'b0;  ifc.in_imm = '0;  ifc.alu_d = '0;  ifc.alu_fo = '0;
    ifc3.in_valid = 1'b0;  ifc3.in_op = '0;  ifc3.in_rd = '0;  ifc3.in_rs1 = '0;
    ifc3.in_rs2 = '0;  ifc3.in_imm_en = 1'b0;  ifc3.in_imm = '0;  ifc3.alu_d = '0;  ifc3.alu_fo = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = '0;
    ref_flags = '0;  ref_wb_rd = '0;  ref_wb_data = '0;

    repeat (2) @(posedge clk);
    #1;
    ifc.in_valid = 1'b1;
    #1;
    chk("rst_ready_low", ifc.in_ready === 1'b0, ifc.in_ready, 1'b0);
    ifc.in_valid = 1'b0;
    rst = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("rst_alu_a", ifc.alu_a === 8'h00, ifc.alu_a, 8'h00);
    chk("rst_alu_b", ifc.alu_b === 8'h00, ifc.alu_b, 8'h00);
    chk("rst_alu_op", ifc.alu_op === 7'h00, ifc.alu_op, 7'h00);
    chk("rst_alu_fi", ifc.alu_fi === 8'h00, ifc.alu_fi, 8'h00);
    chk("rst_wb_valid", ifc.wb_valid === 1'b0, ifc.wb_valid, 1'b0);
    chk("rst_wb_rd", ifc.wb_rd === 2'h0, ifc.wb_rd, 2'h0);
    chk("rst_wb_data", ifc.wb_data === 8'h00, ifc.wb_data, 8'h00);
    chk("rst_flags", ifc.flags === 8'h00, ifc.flags, 8'h00);
    chk("rst_ready", ifc.in_ready === 1'b1, ifc.in_ready, 1'b1);
    repeat (4) idle_cycle();

    // Back-to-back dependency: B reads r2 and flags written by A in the same WB cycle
    do_instr(7'h11, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'd43, 8'h01);
    do_instr(7'h22, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 8'h5A, 8'h10);
    idle_cycle();

`ifdef ALU_SEQ_IMM_EN
    do_instr(7'd1, 2'd1, 2'd0, 2'd0, 1'b1, 8'd100, 8'd101, 8'h00);
    chk("imm_r1_model", ref_rf[1] === 8'd101, ref_rf[1], 8'd101);
    do_instr(7'h05, 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h33, 8'h02);
`else
    do_instr(7'h07, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'd7, 8'h00);
    do_instr(7'h08, 2'd0, 2'd1, 2'd2, 1'b1, 8'd55, 8'h44, 8'h03);
    chk("noimm_alu_b", ifc.alu_b === 8'd7, ifc.alu_b, 8'd7);
`endif
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      do_instr(7'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) idle_cycle();
      end
    end
    idle_cycle();

    // Latency 3: accept at edge N, WB only in cycle N+4, busy-time valid ignored
    #1;
    chk("l3_ready_idle", ifc3.in_ready === 1'b1, ifc3.in_ready, 1'b1);
    ifc3.in_valid = 1'b1;  ifc3.in_op = 7'h5A;  ifc3.in_rd = 2'd1;
    ifc3.in_rs1 = 2'd0;  ifc3.in_rs2 = 2'd0;  ifc3.alu_d = 8'hEE;  ifc3.alu_fo = 8'hEE;
    @(posedge clk); #1;
    ifc3.in_op = 7'h01;  ifc3.in_rd = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      chk("l3_wb_valid", ifc3.wb_valid === (k == 4), ifc3.wb_valid, (k == 4));
      chk("l3_ready", ifc3.in_ready === (k >= 4), ifc3.in_ready, (k >= 4));
      chk("l3_alu_op_held", ifc3.alu_op === 7'h5A, ifc3.alu_op, 7'h5A);
      if (k == 4) begin
        chk("l3_wb_rd", ifc3.wb_rd === 2'd1, ifc3.wb_rd, 2'd1);
        chk("l3_wb_data", ifc3.wb_data === 8'h3C, ifc3.wb_data, 8'h3C);
        chk("l3_flags", ifc3.flags === 8'h81, ifc3.flags, 8'h81);
      end
      if (k == 5) begin
        chk("l3_wb_rd_retained", ifc3.wb_rd === 2'd1, ifc3.wb_rd, 2'd1);
        chk("l3_wb_data_retained", ifc3.wb_data === 8'h3C, ifc3.wb_data, 8'h3C);
      end
      ifc3.in_valid = (k <= 3);
      ifc3.alu_d  = (k == 3) ? 8'h3C : ((k < 3) ? 8'hEE : 8'h11);
      ifc3.alu_fo = (k == 3) ? 8'h81 : ((k < 3) ? 8'hEE : 8'h11);
      @(posedge clk); #1;
    end

    // Reset during WAIT with pending rd=3 abandons the instruction
    ifc3.in_valid = 1'b1;  ifc3.in_op = 7'h33;  ifc3.in_rd = 2'd3;
    ifc3.in_rs1 = 2'd1;  ifc3.in_rs2 = 2'd1;  ifc3.alu_d = 8'h99;  ifc3.alu_fo = 8'h7F;
    @(posedge clk); #1;
    ifc3.in_valid = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("l3_rst_ready_low", ifc3.in_ready === 1'b0, ifc3.in_ready, 1'b0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    #1;
    chk("l3_rst_ready", ifc3.in_ready === 1'b1, ifc3.in_ready, 1'b1);
    chk("l3_rst_flags", ifc3.flags === 8'h00, ifc3.flags, 8'h00);
    chk("l3_rst_wb_data", ifc3.wb_data === 8'h00, ifc3.wb_data, 8'h00);
    chk("l3_rst_alu_op", ifc3.alu_op === 7'h00, ifc3.alu_op, 7'h00);
    for (int k = 0; k < 4; k++) begin
      chk("l3_rst_no_wb", ifc3.wb_valid === 1'b0, ifc3.wb_valid, 1'b0);
      chk("l3_rst_flags_hold", ifc3.flags === 8'h00, ifc3.flags, 8'h00);
      @(posedge clk); #1;
    end
    ifc3.in_valid = 1'b1;  ifc3.in_op = 7'h44;  ifc3.in_rd = 2'd0;
    ifc3.in_rs1 = 2'd3;  ifc3.in_rs2 = 2'd1;
    @(posedge clk); #1;
    ifc3.in_valid = 1'b0;
    chk("l3_r3_zero", ifc3.alu_a === 8'h00, ifc3.alu_a, 8'h00);
    chk("l3_r1_cleared", ifc3.alu_b === 8'h00, ifc3.alu_b, 8'h00);
    chk("l3_fi_zero", ifc3.alu_fi === 8'h00, ifc3.alu_fi, 8'h00);
    chk("l3_issue_op", ifc3.alu_op === 7'h44, ifc3.alu_op, 7'h44);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1, meaning clock edges from operand issue to valid ALU result (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: instruction handshake; transfer when both high at a rising edge.
REQ-005 SHALL have port in_op  input  7  ALU op code, forwarded unchanged.
REQ-006 SHALL have ports in_rd, in_rs1, in_rs2  input  2 each: destination and source register indices.
REQ-007 SHALL have ports in_imm_en input 1 and in_imm input 8: immediate select and value for operand b.
REQ-008 SHALL have ports alu_a, alu_b output 8, alu_op output 7, alu_fi output 8: operands, op, flags-in to downstream ALU.
REQ-009 SHALL have ports alu_d input 8, alu_fo input 8: ALU result and flags-out.
REQ-010 SHALL have ports wb_valid output 1, wb_rd output 2, wb_data output 8, flags output 8: writeback report and architectural flags.

Function
REQ-011 SHALL hold a 4x8 register file r0..r3 (all writable) and an 8-bit flags register.
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, WB.
REQ-013 in_ready SHALL be high in IDLE and WB, low in ISSUE, WAIT and while rst is high.
REQ-014 On accept: latch op/rd/rs1/rs2/imm fields; next state ISSUE.
REQ-015 ISSUE: alu_a=r[rs1]; alu_b=r[rs2] (or imm per REQ-026); alu_op=latched op; alu_fi=flags; values registered and held stable through WAIT and WB.
REQ-016 ISSUE->WAIT with latency counter loaded; WAIT lasts ALU_LATENCY-1 cycles (zero when ALU_LATENCY=1, going ISSUE->WB directly).
REQ-017 On the edge entering WB: r[rd]<=alu_d, flags<=alu_fo, wb_rd<=rd, wb_data<=alu_d.
REQ-018 wb_valid SHALL be high exactly during WB (one cycle per instruction); ALU_LATENCY=1 gives wb_valid in the 2nd cycle after the accept edge.
REQ-019 WB -> ISSUE if a new instruction is accepted in WB, else IDLE; peak throughput one instruction per ALU_LATENCY+1 cycles.
REQ-020 Back-to-back dependency (rs == previous rd, or flags) SHALL read the written value; no stall or bypass needed since write precedes ISSUE.
REQ-021 in_valid while in_ready low SHALL be ignored; fields not latched.
REQ-022 Register indices wrap naturally in 2 bits; no out-of-range case.
REQ-023 wb_rd/wb_data SHALL retain last values outside WB; flags output always equals flags register.

Reset
REQ-024 rst high at a rising edge: state IDLE, r0..r3=0, flags=0, alu_a/alu_b/alu_op/alu_fi=0, wb_valid=0, wb_rd=0, wb_data=0, counter=0.
REQ-025 rst mid-instruction (ISSUE/WAIT/WB) SHALL abandon it: no register/flags write, wb_valid low from next cycle.

Configuration
REQ-026 Macro ALU_SEQ_IMM_EN defined: in_imm_en=1 selects latched in_imm as alu_b. Undefined: in_imm/in_imm_en ports present but ignored, alu_b always r[rs2]; no immediate latch logic.

Verification
REQ-027 Reset then idle -> all outputs 0, in_ready=1, wb_valid never high.
REQ-028 (IMM_EN) accept op=1, rd=1, imm_en=1, imm=100; model ALU returns d=101, fo=0x00 -> alu_b=100, wb_valid one cycle, wb_rd=1, wb_data=101, r1=101.
REQ-029 Back-to-back: instr A writes r2=43 in WB while instr B (rs1=2) accepted same cycle -> B's alu_a=43 at ISSUE; fo=0x01 from A appears on alu_fi for B.
REQ-030 ALU_LATENCY=3: accept at edge N -> WAIT 2 cycles, wb_valid high only in cycle N+4; in_valid held high during ISSUE/WAIT not accepted.
REQ-031 rst pulsed during WAIT with pending rd=3 -> r3 stays 0, flags stay 0, no wb_valid, state IDLE after reset.
REQ-032 Macro undefined, imm_en=1, imm=55, r[rs2]=7 -> alu_b=7.
